decode_lifo_ctrl: RTL and testbench

// - Re-orders the traceback decoder's reverse-order bit stream into forward order.
// - Sits after the survivor path memory unit: consumes rev_bit + stack_toggle, emits forward bits via valid/ready.
// - Ping-pong LIFO: one bank fills while the other drains.
// - Discards start-up blocks and flags overrun and block-length errors.

---
 rtl/viterbi_pkg.sv | 7 +
 rtl/lifo_bit_bank.sv | 30 +++
 rtl/decode_lifo_ctrl.sv | 140 ++++++++++++++
 tb/tb_decode_lifo_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants for the Viterbi traceback back end.
// Block length and start-up skip count match the survivor path memory depth.
package viterbi_pkg;
    localparam int VIT_BLK_LEN     = 21;
    localparam int VIT_SKIP_BLOCKS = 3;
    localparam int VIT_CNT_W       = $clog2(VIT_BLK_LEN + 1);
endpackage

// File: rtl/lifo_bit_bank.sv
// One block of LIFO storage: BLK_LEN single-bit registers, one write port
// and one combinational read port. Out-of-range indices write nothing, read 0.
module lifo_bit_bank
    import viterbi_pkg::*;
#(
    parameter int BLK_LEN = VIT_BLK_LEN,
    parameter int CNT_W   = VIT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_wr_idx,
    input  logic             i_wr_bit,
    input  logic [CNT_W-1:0] i_rd_idx,
    output logic             o_rd_bit
);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(BLK_LEN);

    logic [BLK_LEN-1:0] r_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bits <= '0;
        end else if (i_we && (i_wr_idx < LEN_C)) begin
            r_bits[i_wr_idx] <= i_wr_bit;
        end
    end

    assign o_rd_bit = (i_rd_idx < LEN_C) ? r_bits[i_rd_idx] : 1'b0;
endmodule

// File: rtl/decode_lifo_ctrl.sv
// Ping-pong LIFO that turns the traceback's reverse-order bit stream into
// forward order; one bank fills while the other drains over valid/ready.
module decode_lifo_ctrl
    import viterbi_pkg::*;
#(
    parameter int BLK_LEN     = VIT_BLK_LEN,
    parameter int SKIP_BLOCKS = VIT_SKIP_BLOCKS,
    parameter int CNT_W       = $clog2(BLK_LEN + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic in_en,
    input  logic rev_bit,
    input  logic stack_toggle,
    input  logic out_ready,
    input  logic flag_clr,
    output logic out_bit,
    output logic out_valid,
    output logic out_last,
    output logic overflow,
    output logic len_err
);
    localparam int SKIP_W = (SKIP_BLOCKS > 0) ? $clog2(SKIP_BLOCKS + 1) : 1;
    localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(BLK_LEN);
    localparam logic [SKIP_W-1:0] SKIP_C = SKIP_W'(SKIP_BLOCKS);

    logic              r_tog_d;
    logic              r_armed;
    logic              r_wr_bank;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic              r_rd_bank;
    logic [CNT_W-1:0]  r_rd_idx;
    logic              r_rd_pend;
    logic              r_overflow;
    logic              r_len_err;

    logic              w_swap;
    logic              w_skip;
    logic              w_handover;
    logic              w_pop;
    logic              w_final_pop;
    logic              w_full;
    logic              w_len_set;
    logic              w_ovf_set;
    logic              w_wr_en;
    logic              w_wr_bank;
    logic [CNT_W-1:0]  w_wr_idx;
    logic [1:0]        w_we;
    logic [1:0]        w_rd_bit;

    // The arm flag masks the first cycle so a reset taken mid-stream with
    // stack_toggle high does not look like a block boundary.
    assign w_swap      = r_armed & (stack_toggle ^ r_tog_d);
    assign w_skip      = (r_skip_cnt < SKIP_C);
    assign w_handover  = w_swap & ~w_skip;
    assign w_pop       = r_rd_pend & out_ready;
    assign w_final_pop = w_pop & (r_rd_idx == '0);
    assign w_full      = (r_wr_cnt == LEN_C);
    assign w_len_set   = (in_en & ~w_swap & w_full) | (w_swap & ~w_full);
    assign w_ovf_set   = w_handover & r_rd_pend & ~w_final_pop;

    // A bit arriving with the toggle is index 0 of the block in the other bank.
    assign w_wr_en   = in_en & (w_swap | ~w_full);
    assign w_wr_bank = w_swap ? ~r_wr_bank : r_wr_bank;
    assign w_wr_idx  = w_swap ? '0 : r_wr_cnt;
    assign w_we[0]   = w_wr_en & ~w_wr_bank;
    assign w_we[1]   = w_wr_en & w_wr_bank;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        lifo_bit_bank #(.BLK_LEN(BLK_LEN), .CNT_W(CNT_W)) u_bank (
            .clk      (clk),
            .reset    (reset),
            .i_we     (w_we[g]),
            .i_wr_idx (w_wr_idx),
            .i_wr_bit (rev_bit),
            .i_rd_idx (r_rd_idx),
            .o_rd_bit (w_rd_bit[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tog_d    <= 1'b0;
            r_armed    <= 1'b0;
            r_wr_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_skip_cnt <= '0;
            r_rd_bank  <= 1'b0;
            r_rd_idx   <= '0;
            r_rd_pend  <= 1'b0;
            r_overflow <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_tog_d <= stack_toggle;
            r_armed <= 1'b1;

            if (w_swap) begin
                r_wr_bank <= ~r_wr_bank;
                r_wr_cnt  <= CNT_W'(in_en);
                if (w_skip) begin
                    r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
                end
            end else if (in_en && !w_full) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end

            // A new block always replaces whatever is still draining.
            if (w_handover) begin
                r_rd_bank <= r_wr_bank;
                r_rd_idx  <= (r_wr_cnt != '0) ? (r_wr_cnt - CNT_W'(1)) : '0;
                r_rd_pend <= (r_wr_cnt != '0);
            end else if (w_pop) begin
                if (r_rd_idx == '0) begin
                    r_rd_pend <= 1'b0;
                end else begin
                    r_rd_idx <= r_rd_idx - CNT_W'(1);
                end
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (flag_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_len_set) begin
                r_len_err <= 1'b1;
            end else if (flag_clr) begin
                r_len_err <= 1'b0;
            end
        end
    end

    assign out_valid = r_rd_pend;
    assign out_bit   = w_rd_bit[r_rd_bank];
    assign out_last  = r_rd_pend & (r_rd_idx == '0);
    assign overflow  = r_overflow;
    assign len_err   = r_len_err;
endmodule

// File: tb/tb_decode_lifo_ctrl.sv
// Bench for decode_lifo_ctrl: queue-based reversal model checked every cycle,
// plus directed block sequences with hand-computed expectations.
module tb_decode_lifo_ctrl;
    localparam int BLK  = 21;
    localparam int SKIP = 3;
    localparam logic [31:0] PAT_A = 32'h001A5C3D;
    localparam logic [31:0] PAT_B = 32'h01F09A63;
    localparam logic [31:0] PAT_C = 32'h00152B7E;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_en = 1'b0;
    logic rev_bit = 1'b0;
    logic stack_toggle = 1'b0;
    logic out_ready = 1'b0;
    logic flag_clr = 1'b0;
    logic out_bit, out_valid, out_last, overflow, len_err;

    int total = 0;
    int bad = 0;

    decode_lifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .in_en        (in_en),
        .rev_bit      (rev_bit),
        .stack_toggle (stack_toggle),
        .out_ready    (out_ready),
        .flag_clr     (flag_clr),
        .out_bit      (out_bit),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .overflow     (overflow),
        .len_err      (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the open block as a queue, the drained block as a
    // queue already in forward order.
    bit m_cur[$];
    bit m_pend[$];
    bit m_tog_prev = 1'b0;
    bit m_armed = 1'b0;
    bit m_ovf = 1'b0;
    bit m_lerr = 1'b0;
    int m_skip = 0;
    bit m_sw, m_ovs, m_les;
    int m_n;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cur.delete();
            m_pend.delete();
            m_tog_prev = 1'b0;
            m_armed = 1'b0;
            m_ovf = 1'b0;
            m_lerr = 1'b0;
            m_skip = 0;
        end else begin
            m_sw = m_armed && (stack_toggle != m_tog_prev);
            m_ovs = 1'b0;
            m_les = 1'b0;
            if (m_pend.size() > 0 && out_ready) void'(m_pend.pop_front());
            if (m_sw) begin
                m_n = m_cur.size();
                if (m_n != BLK) m_les = 1'b1;
                if (m_skip < SKIP) begin
                    m_skip++;
                end else begin
                    if (m_pend.size() > 0) m_ovs = 1'b1;
                    m_pend.delete();
                    for (int i = m_n - 1; i >= 0; i--) m_pend.push_back(m_cur[i]);
                end
                m_cur.delete();
                if (in_en) m_cur.push_back(rev_bit);
            end else if (in_en) begin
                if (m_cur.size() == BLK) m_les = 1'b1;
                else m_cur.push_back(rev_bit);
            end
            if (m_ovs) m_ovf = 1'b1;
            else if (flag_clr) m_ovf = 1'b0;
            if (m_les) m_lerr = 1'b1;
            else if (flag_clr) m_lerr = 1'b0;
            m_tog_prev = stack_toggle;
            m_armed = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", out_valid, m_pend.size() != 0);
            if (m_pend.size() != 0) begin
                chk("out_bit", out_bit, m_pend[0]);
                chk("out_last", out_last, m_pend.size() == 1);
            end else begin
                chk("out_last_idle", out_last, 1'b0);
            end
            chk("overflow", overflow, m_ovf);
            chk("len_err", len_err, m_lerr);
        end
    end

    // Log of accepted output bits, first accepted bit ends up most significant.
    int log_n = 0;
    int log_lasts = 0;
    int log_last_pos = 0;
    logic [63:0] log_word = '0;

    task automatic clear_log();
        log_n = 0;
        log_lasts = 0;
        log_last_pos = 0;
        log_word = '0;
    endtask

    task automatic cycle(input logic en, input logic b, input logic tg, input logic rdy, input logic clr);
        in_en = en;
        rev_bit = b;
        stack_toggle = tg;
        out_ready = rdy;
        flag_clr = clr;
        #1;
        if (out_valid === 1'b1 && out_ready) begin
            log_n++;
            log_word = {log_word[62:0], out_bit};
            if (out_last === 1'b1) begin
                log_lasts++;
                log_last_pos = log_n;
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(1'b0, 1'b0, stack_toggle, 1'b1, 1'b0);
    endtask

    // n data cycles then one toggle cycle that closes the block.
    task automatic send_block(input int n, input logic [31:0] pat, input int pct,
                              input int rdy_first, input logic clr_tog);
        logic r;
        for (int i = 0; i < n; i++) begin
            r = (i < rdy_first) || ($urandom_range(99) < pct);
            cycle(1'b1, pat[i % 32], stack_toggle, r, 1'b0);
        end
        r = (n < rdy_first) || ($urandom_range(99) < pct);
        cycle(1'b0, 1'b0, ~stack_toggle, r, clr_tog);
    endtask

    task automatic do_reset(input logic tg);
        reset = 1'b1;
        stack_toggle = tg;
        in_en = 1'b0;
        out_ready = 1'b1;
        flag_clr = 1'b0;
        #1;
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic startup_run(input string tag);
        clear_log();
        repeat (SKIP) send_block(BLK, PAT_A, 100, 0, 1'b0);
        chk({tag, "_skip_silent"}, log_n, 0);
        send_block(BLK, PAT_A, 100, 0, 1'b0);
        send_block(BLK, PAT_B, 100, 0, 1'b0);
        chk({tag, "_blk4_count"}, log_n, 21);
        chk({tag, "_blk4_word"}, log_word[20:0], 21'h1A5C3D);
        chk({tag, "_blk4_lasts"}, log_lasts, 1);
        chk({tag, "_blk4_last_pos"}, log_last_pos, 21);
    endtask

    initial begin
        @(negedge clk);
        #1;
        do_reset(1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        startup_run("startup");

        // Sustained 22-cycle period: the block closed last must drain next.
        clear_log();
        send_block(BLK, PAT_C, 100, 0, 1'b0);
        chk("sustain_word", log_word[20:0], 21'h109A63);
        chk("sustain_count", log_n, 21);

        // Reset while a block drains, stack_toggle high through release.
        idle(5);
        do_reset(1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("post_rst_no_swap", out_valid, 1'b0);
        startup_run("rst_mid");

        // Overrun: X drains 5 bits, then stalls while Y fills and closes.
        idle(22);
        send_block(BLK, PAT_A, 100, 0, 1'b0);
        clear_log();
        send_block(BLK, PAT_B, 0, 5, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        send_block(BLK, PAT_C, 100, 0, 1'b0);
        chk("ovf_count", log_n, 26);
        chk("ovf_lasts", log_lasts, 1);
        chk("ovf_last_pos", log_last_pos, 26);
        chk("ovf_next_word", log_word[20:0], 21'h109A63);
        cycle(1'b0, 1'b0, stack_toggle, 1'b1, 1'b1);
        chk("ovf_clr", overflow, 1'b0);

        // Short block of 15.
        idle(22);
        clear_log();
        send_block(15, PAT_A, 100, 0, 1'b0);
        chk("short_len_err", len_err, 1'b1);
        idle(16);
        chk("short_count", log_n, 15);
        chk("short_word", log_word[14:0], 15'h5C3D);
        chk("short_last_pos", log_last_pos, 15);

        // Long block of 25: only 21 bits kept.
        cycle(1'b0, 1'b0, stack_toggle, 1'b1, 1'b1);
        chk("long_pre_clr", len_err, 1'b0);
        clear_log();
        send_block(25, PAT_B, 100, 0, 1'b0);
        chk("long_len_err", len_err, 1'b1);
        idle(22);
        chk("long_count", log_n, 21);
        chk("long_word", log_word[20:0], 21'h109A63);

        // Toggle lands on the final pop of the previous block.
        cycle(1'b0, 1'b0, stack_toggle, 1'b1, 1'b1);
        send_block(BLK, PAT_A, 100, 0, 1'b0);
        send_block(20, PAT_B, 100, 0, 1'b0);
        chk("final_pop_no_ovf", overflow, 1'b0);
        chk("final_pop_next_valid", out_valid, 1'b1);

        // flag_clr coinciding with a length error: set wins.
        idle(22);
        chk("clr_pending", len_err, 1'b1);
        send_block(10, PAT_C, 100, 0, 1'b1);
        chk("clr_vs_set", len_err, 1'b1);
        cycle(1'b0, 1'b0, stack_toggle, 1'b1, 1'b1);
        chk("clr_alone", len_err, 1'b0);

        // Random back-pressure at 70%.
        idle(22);
        for (int k = 0; k < 1000; k++) begin
            send_block(BLK, $urandom, 70, 0, 1'b0);
        end
        idle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
